// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam int MD_WIDTH = 32;

  // Op_SEL encodings; 6 and 7 are reserved and ignored.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // True for the four iterating operations (mult, multu, div, divu).
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/hilo_muldiv_signfix.sv
// Conditional two's-complement negation: magnitude extraction on the way
// in and sign restoration on the way out.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? ({W{1'b0}} - val_i) : val_i;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Handshake: Start is a one-cycle request honoured only in IDLE (and only
// when Flush is low); Stall holds the pipeline while Busy or while a
// mul/div request is being accepted; Done pulses once when HI/LO change
// with a mul/div result.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [2:0]       Op_SEL,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       dbg_state_o
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {remainder, quotient} or {product hi, multiplier/product lo}
  logic [WIDTH-1:0]   bop_q, bop_d;      // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d; // negate product / quotient
  logic               neg_hi_q, neg_hi_d; // negate remainder (dividend sign)
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign signed_op = (Op_SEL == MD_MULT) || (Op_SEL == MD_DIV);
  assign sign_a    = signed_op & Op1[WIDTH-1];
  assign sign_b    = signed_op & Op2[WIDTH-1];

  muldiv_signfix #(.W(WIDTH))   u_mag_a    (.val_i(Op1), .neg_i(sign_a), .res_o(mag_a));
  muldiv_signfix #(.W(WIDTH))   u_mag_b    (.val_i(Op2), .neg_i(sign_b), .res_o(mag_b));
  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_lo_q), .res_o(prod_fix));
  muldiv_signfix #(.W(WIDTH))   u_fix_quo  (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .res_o(quo_fix));
  muldiv_signfix #(.W(WIDTH))   u_fix_rem  (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_hi_q), .res_o(rem_fix));

  // One iteration step for each algorithm; the FSM picks one.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bop_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, bop_q};
    // A set top bit means the trial subtraction went negative: restore.
    if (div_diff[WIDTH]) div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else                 div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Next-state, datapath and HI/LO write selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bop_d    = bop_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          case (Op_SEL)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = RUN;
              cnt_d    = '0;
              is_div_d = (Op_SEL == MD_DIV) || (Op_SEL == MD_DIVU);
              neg_lo_d = sign_a ^ sign_b;
              neg_hi_d = sign_a;
              if (is_div_d) begin
                acc_d = {{WIDTH{1'b0}}, mag_a};
                bop_d = mag_b;
              end else begin
                acc_d = {{WIDTH{1'b0}}, mag_b};
                bop_d = mag_a;
              end
            end
            MD_MTHI: hi_d = Op1;
            MD_MTLO: lo_d = Op1;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
        if (Flush) state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
        if (!Flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      bop_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bop_q    <= bop_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Stall       = !RESET && (Busy || (Start && is_muldiv(Op_SEL)));
  assign Done        = done_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed and randomized checks of hilo_muldiv against an arithmetic model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_sel = 3'd0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_hi = '0, model_lo = '0;

  hilo_muldiv dut (
    .CLK(clk), .RESET(rst), .Start(start), .Op_SEL(op_sel), .Op1(op1), .Op2(op2),
    .Flush(flush), .Busy(busy), .Stall(stall), .Done(done), .HI(hi), .LO(lo),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) p = {a, (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = {model_hi, model_lo};
    endcase
    return p;
  endfunction

  // Issue one mul/div and check latency, Busy span, Done pulse and result.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int busy_n, cyc;
    bit seen;
    e = model(op, a, b);
    exp_q.push_back(e[63:32]);
    exp_q.push_back(e[31:0]);
    @(negedge clk);
    start = 1'b1; op_sel = op; op1 = a; op2 = b;
    #1 chk("stall_on_start", stall, 1);
    @(negedge clk);
    start = 1'b0; op1 = $urandom; op2 = $urandom;
    busy_n = 0; cyc = 1; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_cycle", cyc, 34);
    chk("busy_cycles", busy_n, 33);
    chk("hi_result", hi, exp_q.pop_front());
    chk("lo_result", lo, exp_q.pop_front());
    model_hi = e[63:32];
    model_lo = e[31:0];
    @(negedge clk);
    chk("done_single_pulse", done, 0);
  endtask

  initial begin
    int done_n;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    // Reset: Stall must be low while RESET is high even with a request.
    start = 1'b1; op_sel = 3'd0;
    #1 chk("stall_in_reset", stall, 0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    run_md(3'd0, 32'hFFFF_FFF9, 32'd3);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_md(3'd3, 32'd100, 32'd0);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'd100);
    run_md(3'd2, 32'hFFFF_FFFB, 32'd0);
    chk("div_zero_neg_lo", lo, 32'd1);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);
    run_md(3'd0, 32'h8000_0000, 32'h8000_0000);

    // mthi then mtlo back to back.
    @(negedge clk);
    start = 1'b1; op_sel = 3'd4; op1 = 32'h1234_5678;
    #1 chk("mthi_no_stall", stall, 0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_kept", lo, model_lo);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    op_sel = 3'd5; op1 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;

    // Reserved op is ignored.
    @(negedge clk);
    start = 1'b1; op_sel = 3'd6; op1 = 32'h5555_5555;
    #1 chk("rsvd_no_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    chk("rsvd_busy", busy, 0);
    chk("rsvd_hi", hi, model_hi);
    chk("rsvd_lo", lo, model_lo);

    // Flush together with mthi in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; op_sel = 3'd4; op1 = 32'hCAFE_F00D; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_mthi_hi", hi, model_hi);

    // multu 5*6 flushed at cycle 10; Start while Busy is ignored.
    @(negedge clk);
    start = 1'b1; op_sel = 3'd1; op1 = 32'd5; op2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_busy_mid", busy, 1);
    chk("flush_stall_mid", stall, 1);
    start = 1'b1; op_sel = 3'd4; op1 = 32'hDEAD_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", busy, 0);
    chk("flush_hi", hi, model_hi);
    chk("flush_lo", lo, model_lo);
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("flush_no_done", done_n, 0);
    chk("flush_hi_late", hi, model_hi);
    chk("flush_lo_late", lo, model_lo);

    // RESET at cycle 20 of a div.
    @(negedge clk);
    start = 1'b1; op_sel = 3'd2; op1 = 32'd100; op2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1; start = 1'b1; op_sel = 3'd0;
    #1 chk("rst_mid_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_busy", busy, 0);
    model_hi = '0;
    model_lo = '0;
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2);

    // Randomized operations, with occasional zero and -1 divisors.
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 255));
        default: ;
      endcase
      run_md(rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the Op1/Op2 operand pair produced by the EX operand-select logic (Op1 = rs data, Op2 = rt data) for mult, multu, div, divu, mthi and mtlo.
- Returns HI/LO to the EX result path for mfhi/mflo.
- Drives a stall request so the hazard unit freezes IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- Op_SEL  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (ignored).
- Op1  input  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source).
- Op2  input  WIDTH  rt operand (multiplier / divisor).
- Flush  input  1  abort the in-flight operation (pipeline flush).
- Busy  output  1  high while an operation is iterating.
- Stall  output  1  high when Busy, or when Start is asserted with a mul/div Op_SEL in IDLE.
- Done  output  1  one-cycle pulse in the cycle HI/LO show a new mul/div result.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset: one clock, synchronous, active-high. On the RESET edge:
  - state goes to IDLE;
  - HI, LO, counter and working registers clear to 0;
  - Busy, Done and Stall are 0 (Stall combinationally 0 while RESET is high).
  - RESET mid-operation discards the operation.
- States:
  - IDLE:
    - Start with Op_SEL 0-3: latch operands and go to RUN, counter = 0.
    - Start with Op_SEL 4: HI <= Op1 at the next edge; stay in IDLE; no Busy, no Done.
    - Start with Op_SEL 5: LO <= Op1 at the next edge; stay in IDLE; no Busy, no Done.
    - Start with Op_SEL 6-7: ignored.
  - RUN:
    - Busy = 1; one iteration per cycle; counter increments.
    - When the counter reaches WIDTH-1, the next edge goes to DONE.
  - DONE:
    - Apply the sign fix-up and write HI/LO at the edge leaving DONE.
    - Done = 1 in the following cycle (IDLE).
    - Busy = 1 while in DONE.
- Latency:
  - Start at edge N.
  - Busy high for cycles N+1 .. N+WIDTH+1.
  - HI/LO updated and Done = 1 in cycle N+WIDTH+2; WIDTH+2 = 34 cycles for WIDTH = 32.
- Multiply:
  - Shift-add on magnitudes. Signed: magnitude = two's-complement negation when the MSB is set.
  - The 2*WIDTH product is negated at fix-up if the operand signs differ.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated if signs differ (signed); remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - Signed -2^31 / -1: LO = 0x80000000, HI = 0 (natural wrap).
- Divide by zero (deterministic, no exception):
  - LO = all ones for divu.
  - For div: LO = all ones if dividend >= 0, else 1.
  - HI = dividend.
  - Normal latency.
- Start while Busy: ignored, no queueing. The hazard unit guarantees this never happens; the bench checks it anyway.
- Flush:
  - Flush in RUN or DONE: return to IDLE at the next edge; HI/LO unchanged; no Done.
  - Flush with Start in the same IDLE cycle: Flush wins; nothing is accepted, including mthi/mtlo.
- Done and Flush never both 1 in one cycle.

Decomposition:
- Shared package:
  - Op_SEL encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - State encodings: IDLE = 0, RUN = 1, DONE = 2.
  - WIDTH default.
- One natural sub-module, muldiv_signfix: combinational magnitude/negation helper used at operand latch and at result fix-up.
- The iteration datapath stays in hilo_muldiv.

Test Plan:
- multu Op1 = 0xFFFFFFFF, Op2 = 0xFFFFFFFF -> after 34 cycles HI = 0xFFFFFFFE, LO = 0x00000001, Done pulses once, Busy high 33 cycles.
- mult Op1 = -7 (0xFFFFFFF9), Op2 = 3 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- div Op1 = -7, Op2 = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); divu 100/0 -> LO = 0xFFFFFFFF, HI = 100.
- mthi Op1 = 0x12345678 then mtlo Op1 = 0x9ABCDEF0 on back-to-back cycles -> HI/LO updated one edge after each, Busy/Done never high.
- Start multu 5*6, Flush at cycle 10 -> IDLE next edge, HI/LO keep prior values, no Done; second Start while Busy ignored.
- RESET asserted at cycle 20 of a div -> next edge HI = LO = 0, Busy = 0; a fresh Start after RESET deasserts completes normally.
